// File: rtl/dragon_pkg.sv
// Shared geometry, direction codes and FSM state type for the dragon body chain.
package dragon_pkg;
    localparam int POS_W            = 8;
    localparam int DIR_W            = 2;
    localparam int SLOT_W           = POS_W + DIR_W;
    localparam int MAX_SEGMENTS_DEF = 8;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic {ST_SYNC, ST_TRACK} chain_state_e;

    function automatic logic [15:0] thermometer(input logic [3:0] n);
        return (16'd1 << n) - 16'd1;
    endfunction
endpackage

// File: rtl/dragon_segment_reg.sv
// One chain slot: a {pos, dir} register that loads from the slot ahead when shifting.
module dragon_segment_reg
    import dragon_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic [SLOT_W-1:0] slot_i,
    output logic [SLOT_W-1:0] slot_o
);
    logic [SLOT_W-1:0] slot_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slot_q <= '0;
        else if (shift_en_i)
            slot_q <= slot_i;
    end

    assign slot_o = slot_q;
endmodule

// File: rtl/dragon_body_chain.sv
// Body chain tracker: shifts trailing segments on head moves, applies grow/shrink
// requests one per shift and flags head-on-body overlap.
module dragon_body_chain
    import dragon_pkg::*;
#(
    parameter int MAX_SEGMENTS = MAX_SEGMENTS_DEF,
    parameter int INIT_LENGTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vsync,
    input  logic [POS_W-1:0]          head_pos,
    input  logic [DIR_W-1:0]          head_dir,
    input  logic                      grow,
    input  logic                      shrink,
    output logic [POS_W*MAX_SEGMENTS-1:0] segment_pos,
    output logic [DIR_W*MAX_SEGMENTS-1:0] segment_dir,
    output logic [MAX_SEGMENTS-1:0]   segment_active,
    output logic [3:0]                length,
    output logic                      head_hit_body
);
    localparam logic [3:0] MAX_LEN  = 4'(MAX_SEGMENTS);
    localparam logic [3:0] INIT_LEN = 4'(INIT_LENGTH);

    chain_state_e      state_q, state_d;
    logic [POS_W-1:0]  prev_head_q, prev_head_d;
    logic [DIR_W-1:0]  prev_dir_q, prev_dir_d;
    logic [3:0]        length_q, length_d;
    logic [1:0]        grow_pend_q, grow_pend_d;
    logic [1:0]        shrink_pend_q, shrink_pend_d;
    logic              hit_q, hit_d;
    logic              shift, grow_dec, shrink_dec, hit_any;
    logic [SLOT_W-1:0] slot_in  [MAX_SEGMENTS];
    logic [SLOT_W-1:0] slot_out [MAX_SEGMENTS];

    // Decrement is only requested when the counter is non-zero, so no underflow.
    function automatic logic [1:0] pend_next(input logic [1:0] cur, input logic dec,
                                             input logic inc);
        logic [2:0] t;
        t = {1'b0, cur} - {2'b00, dec} + {2'b00, inc};
        return (t > 3'd3) ? 2'd3 : t[1:0];
    endfunction

    for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign slot_in[i] = {prev_head_q, prev_dir_q};
        end else begin : g_tail
            assign slot_in[i] = slot_out[i-1];
        end

        dragon_segment_reg u_seg (
            .clk        (clk),
            .reset      (reset),
            .shift_en_i (shift),
            .slot_i     (slot_in[i]),
            .slot_o     (slot_out[i])
        );

        assign segment_pos[POS_W*i +: POS_W] = slot_out[i][SLOT_W-1:DIR_W];
        assign segment_dir[DIR_W*i +: DIR_W] = slot_out[i][DIR_W-1:0];
    end

    assign segment_active = MAX_SEGMENTS'(thermometer(length_q));
    assign length         = length_q;
    assign head_hit_body  = hit_q;

    // Overlap uses the slot contents before this cycle's shift lands.
    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if (segment_active[i] && (head_pos == slot_out[i][SLOT_W-1:DIR_W]))
                hit_any = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            prev_head_q   <= '0;
            prev_dir_q    <= '0;
            length_q      <= INIT_LEN;
            grow_pend_q   <= '0;
            shrink_pend_q <= '0;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_head_q   <= prev_head_d;
            prev_dir_q    <= prev_dir_d;
            length_q      <= length_d;
            grow_pend_q   <= grow_pend_d;
            shrink_pend_q <= shrink_pend_d;
            hit_q         <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_head_d = prev_head_q;
        prev_dir_d  = prev_dir_q;
        length_d    = length_q;
        hit_d       = hit_q;
        shift       = 1'b0;
        grow_dec    = 1'b0;
        shrink_dec  = 1'b0;

        case (state_q)
            ST_SYNC: begin
                hit_d = 1'b0;
                if (vsync) begin
                    prev_head_d = head_pos;
                    prev_dir_d  = head_dir;
                    state_d     = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (vsync) begin
                    hit_d      = hit_any;
                    prev_dir_d = head_dir;
                    if (head_pos != prev_head_q) begin
                        shift       = 1'b1;
                        prev_head_d = head_pos;
                        // A request at a length limit is consumed without effect.
                        if (grow_pend_q != 2'd0 && shrink_pend_q != 2'd0) begin
                            grow_dec   = 1'b1;
                            shrink_dec = 1'b1;
                        end else if (grow_pend_q != 2'd0) begin
                            grow_dec = 1'b1;
                            if (length_q < MAX_LEN)
                                length_d = length_q + 4'd1;
                        end else if (shrink_pend_q != 2'd0) begin
                            shrink_dec = 1'b1;
                            if (length_q > 4'd1)
                                length_d = length_q - 4'd1;
                        end
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase

        grow_pend_d   = pend_next(grow_pend_q, grow_dec, grow);
        shrink_pend_d = pend_next(shrink_pend_q, shrink_dec, shrink);
    end
endmodule

// File: tb/tb_dragon_body_chain.sv
// Bench for dragon_body_chain: directed vector table, corner sequences and a random run vs a model.
module tb_dragon_body_chain;
    localparam int MAXS = 8;
    localparam int INIT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              vsync;
    logic [7:0]        head_pos;
    logic [1:0]        head_dir;
    logic              grow, shrink;
    logic [8*MAXS-1:0] segment_pos;
    logic [2*MAXS-1:0] segment_dir;
    logic [MAXS-1:0]   segment_active;
    logic [3:0]        length;
    logic              head_hit_body;

    int n_cmp = 0;
    int n_err = 0;

    dragon_body_chain #(.MAX_SEGMENTS(MAXS), .INIT_LENGTH(INIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .vsync          (vsync),
        .head_pos       (head_pos),
        .head_dir       (head_dir),
        .grow           (grow),
        .shrink         (shrink),
        .segment_pos    (segment_pos),
        .segment_dir    (segment_dir),
        .segment_active (segment_active),
        .length         (length),
        .head_hit_body  (head_hit_body)
    );

    always #5 clk = ~clk;

    // Reference model: the chain as plain arrays plus integer counters.
    logic [7:0] m_pos [MAXS];
    logic [1:0] m_dir [MAXS];
    int         m_len, m_gp, m_sp;
    logic [7:0] m_prev;
    logic [1:0] m_pdir;
    bit         m_sync, m_hit;

    task automatic m_reset();
        for (int i = 0; i < MAXS; i++) begin
            m_pos[i] = 8'h00;
            m_dir[i] = 2'b00;
        end
        m_len = INIT; m_gp = 0; m_sp = 0;
        m_prev = 8'h00; m_pdir = 2'b00; m_sync = 1; m_hit = 0;
    endtask

    task automatic m_step(input logic vs, input logic [7:0] hp, input logic [1:0] hd,
                          input logic g, input logic s);
        if (m_sync) begin
            if (vs) begin
                m_prev = hp; m_pdir = hd; m_sync = 0;
            end
        end else if (vs) begin
            m_hit = 0;
            for (int i = 0; i < m_len; i++)
                if (m_pos[i] == hp) m_hit = 1;
            if (hp != m_prev) begin
                for (int i = MAXS - 1; i > 0; i--) begin
                    m_pos[i] = m_pos[i-1];
                    m_dir[i] = m_dir[i-1];
                end
                m_pos[0] = m_prev; m_dir[0] = m_pdir; m_prev = hp;
                if (m_gp > 0 && m_sp > 0) begin
                    m_gp--; m_sp--;
                end else if (m_gp > 0) begin
                    m_gp--;
                    if (m_len < MAXS) m_len++;
                end else if (m_sp > 0) begin
                    m_sp--;
                    if (m_len > 1) m_len--;
                end
            end
            m_pdir = hd;
        end
        m_gp = (m_gp + int'(g) > 3) ? 3 : m_gp + int'(g);
        m_sp = (m_sp + int'(s) > 3) ? 3 : m_sp + int'(s);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [8*MAXS-1:0] ep;
        logic [2*MAXS-1:0] ed;
        logic [MAXS-1:0]   ea;
        for (int i = 0; i < MAXS; i++) begin
            ep[8*i +: 8] = m_pos[i];
            ed[2*i +: 2] = m_dir[i];
            ea[i]        = (i < m_len);
        end
        chk({tag, ".len"}, 64'(length), 64'(m_len));
        chk({tag, ".act"}, 64'(segment_active), 64'(ea));
        chk({tag, ".pos"}, 64'(segment_pos), 64'(ep));
        chk({tag, ".dir"}, 64'(segment_dir), 64'(ed));
        chk({tag, ".hit"}, 64'(head_hit_body), 64'(m_hit));
    endtask

    task automatic cyc(input logic vs, input logic [7:0] hp, input logic [1:0] hd,
                       input logic g, input logic s);
        @(negedge clk);
        vsync = vs; head_pos = hp; head_dir = hd; grow = g; shrink = s;
        @(posedge clk);
        m_step(vs, hp, hd, g, s);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; vsync = 1'b0; grow = 1'b0; shrink = 1'b0;
        m_reset();
        #1;
        chk({tag, ".rst_len"}, 64'(length), 64'(INIT));
        chk({tag, ".rst_act"}, 64'(segment_active), 64'h3);
        chk({tag, ".rst_pos"}, 64'(segment_pos), 64'h0);
        chk({tag, ".rst_dir"}, 64'(segment_dir), 64'h0);
        chk({tag, ".rst_hit"}, 64'(head_hit_body), 64'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       vs;
        logic [7:0] hp;
        logic [1:0] hd;
        logic       g, s;
        logic [3:0] e_len;
        logic [7:0] e_act;
        logic [7:0] e_s0;
        logic [1:0] e_d0;
        logic [7:0] e_s1;
        logic       e_hit;
    } vec_t;

    vec_t vt [10];

    initial begin
        reset = 1'b0; vsync = 1'b0; head_pos = 8'h00; head_dir = 2'b00;
        grow = 1'b0; shrink = 1'b0;
        m_reset();

        // sync, moves 0x10/0x20/0x21, then three idle grows and three moves
        vt[0] = '{1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 4'd2, 8'h03, 8'h00, 2'd0, 8'h00, 1'b0};
        vt[1] = '{1'b1, 8'h10, 2'd1, 1'b0, 1'b0, 4'd2, 8'h03, 8'h00, 2'd0, 8'h00, 1'b0};
        vt[2] = '{1'b1, 8'h20, 2'd1, 1'b0, 1'b0, 4'd2, 8'h03, 8'h10, 2'd1, 8'h00, 1'b0};
        vt[3] = '{1'b1, 8'h21, 2'd0, 1'b0, 1'b0, 4'd2, 8'h03, 8'h20, 2'd1, 8'h10, 1'b0};
        vt[4] = '{1'b0, 8'h21, 2'd1, 1'b1, 1'b0, 4'd2, 8'h03, 8'h20, 2'd1, 8'h10, 1'b0};
        vt[5] = '{1'b0, 8'h21, 2'd1, 1'b1, 1'b0, 4'd2, 8'h03, 8'h20, 2'd1, 8'h10, 1'b0};
        vt[6] = '{1'b1, 8'h21, 2'd1, 1'b1, 1'b0, 4'd2, 8'h03, 8'h20, 2'd1, 8'h10, 1'b0};
        vt[7] = '{1'b1, 8'h22, 2'd1, 1'b0, 1'b0, 4'd3, 8'h07, 8'h21, 2'd1, 8'h20, 1'b0};
        vt[8] = '{1'b1, 8'h23, 2'd1, 1'b0, 1'b0, 4'd4, 8'h0F, 8'h22, 2'd1, 8'h21, 1'b0};
        vt[9] = '{1'b1, 8'h24, 2'd1, 1'b0, 1'b0, 4'd5, 8'h1F, 8'h23, 2'd1, 8'h22, 1'b0};

        do_reset("init");
        for (int k = 0; k < 10; k++) begin
            cyc(vt[k].vs, vt[k].hp, vt[k].hd, vt[k].g, vt[k].s);
            chk($sformatf("vec%0d.len", k), 64'(length), 64'(vt[k].e_len));
            chk($sformatf("vec%0d.act", k), 64'(segment_active), 64'(vt[k].e_act));
            chk($sformatf("vec%0d.s0", k), 64'(segment_pos[7:0]), 64'(vt[k].e_s0));
            chk($sformatf("vec%0d.d0", k), 64'(segment_dir[1:0]), 64'(vt[k].e_d0));
            chk($sformatf("vec%0d.s1", k), 64'(segment_pos[15:8]), 64'(vt[k].e_s1));
            chk($sformatf("vec%0d.hit", k), 64'(head_hit_body), 64'(vt[k].e_hit));
        end

        // simultaneous grow and shrink cancel each other
        do_reset("gs");
        cyc(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 8'h10, 2'd1, 1'b0, 1'b0);
        chk("gs.len1", 64'(length), 64'd2);
        cyc(1'b1, 8'h20, 2'd1, 1'b0, 1'b0);
        chk("gs.len2", 64'(length), 64'd2);

        // shrink floor at one segment, excess requests discarded
        do_reset("shr");
        cyc(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 8'(k * 16), 2'd1, 1'b0, 1'b0);
            chk($sformatf("shr.len%0d", k), 64'(length), 64'd1);
            chk($sformatf("shr.act%0d", k), 64'(segment_active), 64'h01);
        end
        cmp_model("shr");

        // grow saturates at MAXS
        do_reset("gmax");
        cyc(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, 8'(k - 1), 2'd0, 1'b1, 1'b0);
            cyc(1'b1, 8'(k), 2'd0, 1'b0, 1'b0);
        end
        chk("gmax.len", 64'(length), 64'(MAXS));
        chk("gmax.act", 64'(segment_active), 64'hFF);

        // head runs into its own body, then mid-frame reset
        do_reset("hit");
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'h10, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 2'd2, 1'b0, 1'b0);
        chk("hit.len", 64'(length), 64'd4);
        cyc(1'b1, 8'h01, 2'd3, 1'b0, 1'b0);
        chk("hit.pre", 64'(head_hit_body), 64'd0);
        cyc(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
        chk("hit.on", 64'(head_hit_body), 64'd1);
        cyc(1'b0, 8'h33, 2'd0, 1'b0, 1'b0);
        chk("hit.hold", 64'(head_hit_body), 64'd1);
        cmp_model("hit");
        do_reset("midrst");

        // random traffic against the model, with occasional resets
        for (int k = 0; k < 600; k++) begin
            if (k == 200 || k == 400) do_reset($sformatf("rnd_rst%0d", k));
            cyc(1'($urandom_range(0, 1)),
                {2'b00, 2'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 1))},
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 5) == 0));
            cmp_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
